// File: rtl/barrido_display_if.sv
// Bus between the digit scanner and its environment: value/load/blank
// controls in, scanned nibble, anode enables and advance tick out.
interface barrido_display_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] valor_i;
  logic                cargar_i;
  logic                blanco_i;
  logic [3:0]          nibble_o;
  logic [DIGITS-1:0]   anodo_o;
  logic                tick_o;

  // Environment side: drives the value and controls, observes the scan.
  modport master (
    output valor_i, cargar_i, blanco_i,
    input  nibble_o, anodo_o, tick_o
  );

  // Scanner side.
  modport slave (
    input  valor_i, cargar_i, blanco_i,
    output nibble_o, anodo_o, tick_o
  );
endinterface

// File: rtl/barrido_display.sv
// Time-multiplexed seven-segment scanner. Keeps a shadow of the displayed
// value, steps through the digits on a prescaled tick, keeps every slot dark
// for GUARD cycles to avoid ghosting, and can blank leading zeros.
module barrido_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  barrido_display_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CONT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_C   = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {OSCURO = 1'b0, ENCENDIDO = 1'b1} estado_t;

  logic [4*DIGITS-1:0] sombra_reg;
  logic [CW-1:0]       cont_reg, cont_next;
  logic [IW-1:0]       idx_reg, idx_next;
  estado_t             estado_reg, estado_next;
  logic                tick_next;
  logic [3:0]          nibble_reg, nibble_next;
  logic [DIGITS-1:0]   anodo_reg, anodo_next;
  logic                tick_reg;
  logic                blank;
  logic                acc_zero;
  logic [DIGITS-1:0]   zero_from;   // bit k: shadow digits k..DIGITS-1 are all zero
  logic [3:0]          digito [DIGITS];

  // Split the shadow register into per-digit nibbles.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digito
      assign digito[gi] = sombra_reg[4*gi +: 4];
    end
  endgenerate

  // Prescaler and digit index: explicit compare-and-clear wrap so that
  // non-power-of-two counts behave.
  always_comb begin
    tick_next = (cont_reg == CONT_LAST);
    cont_next = tick_next ? '0 : cont_reg + 1'b1;
    idx_next  = idx_reg;
    if (tick_next) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // Shadow value, prescaler and digit index registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sombra_reg <= '0;
      cont_reg   <= '0;
      idx_reg    <= '0;
    end else begin
      if (bus.cargar_i) begin
        sombra_reg <= bus.valor_i;
      end
      cont_reg <= cont_next;
      idx_reg  <= idx_next;
    end
  end

  // Slot FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_reg <= OSCURO;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // Slot FSM next state: dark until the prescaler reaches GUARD, lit until the tick.
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      OSCURO:    if (cont_next == GUARD_C) estado_next = ENCENDIDO;
      ENCENDIDO: if (tick_next)            estado_next = OSCURO;
      default:   estado_next = OSCURO;
    endcase
  end

  // Leading-zero detection, scanning from the most significant digit down.
  always_comb begin
    zero_from = '0;
    acc_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc_zero     = acc_zero & (digito[k] == 4'h0);
      zero_from[k] = acc_zero;
    end
  end

  // Slot FSM outputs: nibble always follows idx, anode only lit when not dark/blank.
  always_comb begin
    nibble_next = digito[idx_reg];
    blank       = bus.blanco_i && (idx_reg != '0) && zero_from[idx_reg];
    anodo_next  = '1;
    if (estado_reg == ENCENDIDO && !blank) begin
      anodo_next[idx_reg] = 1'b0;
    end
  end

  // Output registers: one cycle behind the internal scan state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nibble_reg <= 4'h0;
      anodo_reg  <= '1;
      tick_reg   <= 1'b0;
    end else begin
      nibble_reg <= nibble_next;
      anodo_reg  <= anodo_next;
      tick_reg   <= tick_next;
    end
  end

  assign bus.nibble_o = nibble_reg;
  assign bus.anodo_o  = anodo_reg;
  assign bus.tick_o   = tick_reg;
endmodule

// File: tb/tb_barrido_display.sv
// Self-checking bench for barrido_display (DIGITS=4, PRESCALE=8, GUARD=2).
module tb_barrido_display;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int GUARD    = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  barrido_display_if #(.DIGITS(DIGITS)) bus ();

  barrido_display #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected outputs are pushed when the edge consumes stimulus,
  // popped and compared half a cycle later.
  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_push, e_pop;
  int          m_cont = 0, m_idx = 0, o_cont = -1, o_idx = -1;
  logic [15:0] m_sombra = 16'h0;
  logic [15:0] m_upper;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_cont = 0; m_idx = 0; m_sombra = 16'h0; o_cont = -1; o_idx = -1;
      sb_q.delete();
    end else begin
      m_upper     = m_sombra >> (4 * m_idx);
      e_push.nib  = m_sombra[4*m_idx +: 4];
      e_push.an   = 4'hF;
      if (m_cont >= GUARD && !(bus.blanco_i && m_idx != 0 && m_upper == 16'h0))
        e_push.an[m_idx] = 1'b0;
      e_push.tick = (m_cont == PRESCALE - 1);
      sb_q.push_back(e_push);
      o_cont = m_cont;
      o_idx  = m_idx;
      if (m_cont == PRESCALE - 1) begin
        m_cont = 0;
        m_idx  = (m_idx + 1) % DIGITS;
      end else begin
        m_cont++;
      end
      if (bus.cargar_i) m_sombra = bus.valor_i;
    end
  end

  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      e_pop = sb_q.pop_front();
      check("sb_nibble", 32'(bus.nibble_o), 32'(e_pop.nib));
      check("sb_anodo", 32'(bus.anodo_o), 32'(e_pop.an));
      check("sb_tick", 32'(bus.tick_o), 32'(e_pop.tick));
      check("sb_exclusive", 32'($countones(~bus.anodo_o) <= 1), 32'd1);
    end
  end

  // Table of per-slot expectations, sampled mid-way through each lit interval.
  typedef struct {
    logic [15:0] valor;
    logic        blanco;
    logic [3:0]  nib [4];
    logic [3:0]  an  [4];
  } vec_t;

  vec_t tbl [5];

  task automatic load(input logic [15:0] v);
    @(negedge clk_i);
    bus.valor_i  = v;
    bus.cargar_i = 1'b1;
    @(negedge clk_i);
    bus.cargar_i = 1'b0;
  endtask

  // Wait (bounded) for the negedge whose outputs reflect slot i at prescaler c.
  task automatic wait_out(input int i, input int c, input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (o_idx == i && o_cont == c) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s_timeout: slot %0d/%0d not reached", name, i, c);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 1'b0, '{4'h4, 4'h3, 4'h2, 4'h1}, '{4'hE, 4'hD, 4'hB, 4'h7}};
    tbl[1] = '{16'h0050, 1'b1, '{4'h0, 4'h5, 4'h0, 4'h0}, '{4'hE, 4'hD, 4'hF, 4'hF}};
    tbl[2] = '{16'h0000, 1'b1, '{4'h0, 4'h0, 4'h0, 4'h0}, '{4'hE, 4'hF, 4'hF, 4'hF}};
    tbl[3] = '{16'h000F, 1'b0, '{4'hF, 4'h0, 4'h0, 4'h0}, '{4'hE, 4'hD, 4'hB, 4'h7}};
    tbl[4] = '{16'h0A0B, 1'b1, '{4'hB, 4'h0, 4'hA, 4'h0}, '{4'hE, 4'hD, 4'hB, 4'hF}};

    bus.valor_i  = 16'h0;
    bus.cargar_i = 1'b0;
    bus.blanco_i = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_anodo", 32'(bus.anodo_o), 32'hF);
    check("rst_nibble", 32'(bus.nibble_o), 32'h0);
    check("rst_tick", 32'(bus.tick_o), 32'h0);
    rst_i = 1'b0;

    // Table-driven scan order and blanking patterns.
    for (int t = 0; t < 5; t++) begin
      bus.blanco_i = tbl[t].blanco;
      load(tbl[t].valor);
      for (int s = 0; s < DIGITS; s++) begin
        wait_out(s, 5, "tbl");
        check($sformatf("tbl%0d_nib%0d", t, s), 32'(bus.nibble_o), 32'(tbl[t].nib[s]));
        check($sformatf("tbl%0d_an%0d", t, s), 32'(bus.anodo_o), 32'(tbl[t].an[s]));
      end
    end

    // Asynchronous reset mid-slot on digit 2, then first lit anode after release.
    bus.blanco_i = 1'b0;
    load(16'h1234);
    wait_out(2, 4, "rst_mid");
    #2 rst_i = 1'b1;
    #1;
    check("rstmid_anodo", 32'(bus.anodo_o), 32'hF);
    check("rstmid_nibble", 32'(bus.nibble_o), 32'h0);
    check("rstmid_tick", 32'(bus.tick_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rel_edge1_anodo", 32'(bus.anodo_o), 32'hF);
    @(posedge clk_i); #1;
    check("rel_edge2_anodo", 32'(bus.anodo_o), 32'hF);
    @(posedge clk_i); #1;
    check("rel_edge3_anodo", 32'(bus.anodo_o), 32'hE);
    check("rel_edge3_nibble", 32'(bus.nibble_o), 32'h0);

    // Load on the same edge as the tick leaving digit 0.
    load(16'h1234);
    begin : find_tick_edge
      for (int n = 0; n < 100; n++) begin
        @(negedge clk_i);
        if (m_cont == PRESCALE - 1 && m_idx == 0) disable find_tick_edge;
      end
      n_tests++;
      n_fail++;
      $display("FAIL tickload_timeout: cont=7 idx=0 not reached");
    end
    bus.valor_i  = 16'hABCD;
    bus.cargar_i = 1'b1;
    @(posedge clk_i); #1;
    check("tickload_e_tick", 32'(bus.tick_o), 32'h1);
    check("tickload_e_anodo", 32'(bus.anodo_o), 32'hE);
    @(negedge clk_i);
    bus.cargar_i = 1'b0;
    @(posedge clk_i); #1;
    check("tickload_e1_nibble", 32'(bus.nibble_o), 32'hC);
    check("tickload_e1_anodo", 32'(bus.anodo_o), 32'hF);
    check("tickload_e1_tick", 32'(bus.tick_o), 32'h0);
    wait_out(1, 5, "tickload");
    check("tickload_lit_nibble", 32'(bus.nibble_o), 32'hC);
    check("tickload_lit_anodo", 32'(bus.anodo_o), 32'hD);

    // Live blanking toggle while digit 3 is lit.
    bus.blanco_i = 1'b0;
    load(16'h000F);
    wait_out(3, 4, "toggle");
    check("toggle_before", 32'(bus.anodo_o), 32'h7);
    bus.blanco_i = 1'b1;
    @(posedge clk_i); #1;
    check("toggle_on_anodo", 32'(bus.anodo_o), 32'hF);
    @(negedge clk_i);
    bus.blanco_i = 1'b0;
    @(posedge clk_i); #1;
    check("toggle_off_anodo", 32'(bus.anodo_o), 32'h7);
    check("toggle_off_nibble", 32'(bus.nibble_o), 32'h0);

    // Random soak: the scoreboard checks every cycle.
    for (int f = 0; f < 1000 * DIGITS * PRESCALE; f++) begin
      @(negedge clk_i);
      bus.cargar_i = ($urandom_range(0, 15) == 0);
      bus.valor_i  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) bus.blanco_i = ~bus.blanco_i;
    end
    @(negedge clk_i);
    bus.cargar_i = 1'b0;
    repeat (2) @(negedge clk_i);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end
endmodule
